// File: rtl/mat_vec_loader.sv
// mat_vec_loader: upstream feeder for the 8x8 systolic matrix-vector multiplier.
//   On start it clears the multiplier, fetches DEPTH rows of A plus vector B
//   (DEPTH+1 memory words) one read at a time, then streams the data column by
//   column into the multiplier FIFOs with DEPTH back-to-back mm_wren cycles.
//   It then waits for mm_done and pulses ldr_done.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, base_addr     job request (IDLE only) and word address of A row 0
//   busy, ldr_done       job in progress / one-cycle completion pulse
//   mem_*                Avalon-MM-style read master, one read outstanding
//   mm_clr, mm_wren      multiplier clear and FIFO write strobe
//   mm_a_mat, mm_b_vec   column data, zero when mm_wren is low
//   mm_done              multiplier result-ready
module mat_vec_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    output logic                               busy,
    output logic                               ldr_done,
    output logic [ADDR_WIDTH-1:0]              mem_address,
    output logic                               mem_read,
    input  logic                               mem_waitrequest,
    input  logic [DATA_WIDTH*DEPTH-1:0]        mem_readdata,
    input  logic                               mem_readdatavalid,
    output logic                               mm_clr,
    output logic                               mm_wren,
    output logic [0:DEPTH-1][DATA_WIDTH-1:0]   mm_a_mat,
    output logic [DATA_WIDTH-1:0]              mm_b_vec,
    input  logic                               mm_done
);

    localparam int KW = $clog2(DEPTH + 1);
    localparam int JW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RD_REQ,
        S_RD_WAIT,
        S_PUSH,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t                        state_q;
    logic [ADDR_WIDTH-1:0]         base_q;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic [KW-1:0]                 k_q;
    logic [JW-1:0]                 j_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          rd_q;
    logic                          clr_q;
    logic                          wren_q;
    logic [DATA_WIDTH*DEPTH-1:0]   rbuf_q [0:DEPTH];

    // Control outputs are registered alongside the state transition that
    // enters the state they belong to, so they carry no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            k_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            clr_q   <= 1'b0;
            wren_q  <= 1'b0;
            for (int unsigned i = 0; i <= DEPTH; i++) begin
                rbuf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        busy_q  <= 1'b1;
                        clr_q   <= 1'b1;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    clr_q   <= 1'b0;
                    k_q     <= '0;
                    rd_q    <= 1'b1;
                    addr_q  <= base_q;
                    state_q <= S_RD_REQ;
                end
                S_RD_REQ: begin
                    if (!mem_waitrequest) begin
                        rd_q    <= 1'b0;
                        state_q <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_readdatavalid) begin
                        rbuf_q[k_q] <= mem_readdata;
                        if (k_q == KW'(DEPTH)) begin
                            j_q     <= '0;
                            wren_q  <= 1'b1;
                            state_q <= S_PUSH;
                        end else begin
                            k_q     <= k_q + KW'(1);
                            rd_q    <= 1'b1;
                            addr_q  <= base_q + ADDR_WIDTH'(k_q + KW'(1));
                            state_q <= S_RD_REQ;
                        end
                    end
                end
                S_PUSH: begin
                    if (j_q == JW'(DEPTH - 1)) begin
                        wren_q  <= 1'b0;
                        state_q <= S_WAIT_DONE;
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (mm_done) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Transpose: column j of the multiplier input is element j of every row word.
    always_comb begin
        mm_a_mat = '0;
        mm_b_vec = '0;
        if (wren_q) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mm_a_mat[JW'(i)] = rbuf_q[KW'(i)][int'(j_q)*DATA_WIDTH +: DATA_WIDTH];
            end
            mm_b_vec = rbuf_q[KW'(DEPTH)][int'(j_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign busy        = busy_q;
    assign ldr_done    = done_q;
    assign mem_address = addr_q;
    assign mem_read    = rd_q;
    assign mm_clr      = clr_q;
    assign mm_wren     = wren_q;

endmodule

// File: tb/tb_mat_vec_loader.sv
// tb_mat_vec_loader: randomized and directed bench for mat_vec_loader.
//   A memory slave with configurable/random stall and latency serves reads
//   from an associative-array memory; a per-cycle compare process checks every
//   output against a count-based expectation of the load/push/complete flow.
module tb_mat_vec_loader;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [31:0]      base_addr;
    logic             busy;
    logic             ldr_done;
    logic [31:0]      mem_address;
    logic             mem_read;
    logic             mem_waitrequest;
    logic [63:0]      mem_readdata;
    logic             mem_readdatavalid;
    logic             mm_clr;
    logic             mm_wren;
    logic [0:7][7:0]  mm_a_mat;
    logic [7:0]       mm_b_vec;
    logic             mm_done;

    mat_vec_loader #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .busy              (busy),
        .ldr_done          (ldr_done),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .mm_clr            (mm_clr),
        .mm_wren           (mm_wren),
        .mm_a_mat          (mm_a_mat),
        .mm_b_vec          (mm_b_vec),
        .mm_done           (mm_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    logic [63:0] mem [logic [31:0]];

    // memory slave configuration and bookkeeping
    int  cfg_wait = 0;
    int  cfg_lat = 1;
    bit  cfg_rnd = 0;
    bit  spur_req = 0;
    int  acc_cnt = 0;
    int  wren_seen = 0;
    int  clr_seen = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    function automatic logic [63:0] memw(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    function automatic logic [7:0] elem(input logic [31:0] a, input int j);
        logic [63:0] w;
        w = memw(a);
        return w[j*8 +: 8];
    endfunction

    task automatic fill_basic(input logic [31:0] b);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(8*i + j + 1);
            mem[b + 32'(i)] = w;
        end
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(j + 1);
        mem[b + 32'd8] = w;
    endtask

    task automatic fill_rand(input logic [31:0] b);
        for (int i = 0; i <= 8; i++) mem[b + 32'(i)] = {$urandom, $urandom};
    endtask

    // Avalon-MM read slave: stalls, then returns data after a latency.
    initial begin : slave
        int        stall_left;
        int        lat_left;
        bit        in_req;
        logic [31:0] pend;
        stall_left = 0; lat_left = 0; in_req = 0; pend = '0;
        mem_waitrequest = 0;
        mem_readdatavalid = 0;
        mem_readdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                stall_left = 0; lat_left = 0; in_req = 0;
                mem_waitrequest = 0;
                mem_readdatavalid = 0;
                continue;
            end
            mem_readdatavalid = 0;
            mem_readdata = {$urandom, $urandom};
            if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0) begin
                    mem_readdatavalid = 1;
                    mem_readdata = memw(pend);
                end
            end
            if (spur_req) begin
                mem_readdatavalid = 1;
                spur_req = 0;
            end
            mem_waitrequest = 0;
            if (mem_read) begin
                if (!in_req) begin
                    in_req = 1;
                    stall_left = cfg_rnd ? int'($urandom_range(0, 3)) : cfg_wait;
                end
                if (stall_left > 0) begin
                    mem_waitrequest = 1;
                    stall_left--;
                end else begin
                    in_req = 0;
                    pend = mem_address;
                    lat_left = cfg_rnd ? int'($urandom_range(1, 4)) : cfg_lat;
                    acc_cnt++;
                end
            end
        end
    end

    // Reference: one job = clear, 9 sequential reads (next issued the cycle
    // after the previous data returns), 8 consecutive column writes, then
    // completion one cycle after mm_done is seen once the writes are over.
    initial begin : compare
        bit          m_idle, m_busy, m_clr_due, m_cleared, m_ldr_due;
        int          m_reads, m_rdv, m_cols;
        logic [31:0] m_base;
        bit          outst, prev_stall, exp_read, exp_wren;
        logic [31:0] prev_addr;
        m_idle = 1; m_busy = 0; m_clr_due = 0; m_cleared = 0; m_ldr_due = 0;
        m_reads = 0; m_rdv = 0; m_cols = 0; m_base = '0;
        outst = 0; prev_stall = 0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_eq("rst_mem_read", 64'(mem_read), 0);
                chk_eq("rst_mem_address", 64'(mem_address), 0);
                chk_eq("rst_busy", 64'(busy), 0);
                chk_eq("rst_ldr_done", 64'(ldr_done), 0);
                chk_eq("rst_mm_clr", 64'(mm_clr), 0);
                chk_eq("rst_mm_wren", 64'(mm_wren), 0);
                chk_eq("rst_mm_a_mat", 64'(mm_a_mat), 0);
                chk_eq("rst_mm_b_vec", 64'(mm_b_vec), 0);
                m_idle = 1; m_busy = 0; m_clr_due = 0; m_cleared = 0; m_ldr_due = 0;
                m_reads = 0; m_rdv = 0; m_cols = 0;
                outst = 0; prev_stall = 0;
                continue;
            end
            exp_read = m_cleared && (m_reads == m_rdv) && (m_reads < 9);
            exp_wren = (m_rdv == 9) && (m_cols < 8);

            chk_eq("mm_clr", 64'(mm_clr), 64'(m_clr_due));
            chk_eq("busy", 64'(busy), 64'(m_busy));
            chk_eq("ldr_done", 64'(ldr_done), 64'(m_ldr_due));
            chk_eq("mem_read", 64'(mem_read), 64'(exp_read));
            if (exp_read) chk_eq("mem_address", 64'(mem_address), 64'(m_base + 32'(m_reads)));
            if (mem_read) chk_eq("one_outstanding", 64'(outst), 0);
            if (prev_stall) chk_eq("stall_hold_addr", 64'(mem_address), 64'(prev_addr));
            chk_eq("mm_wren", 64'(mm_wren), 64'(exp_wren));
            if (exp_wren) begin
                for (int i = 0; i < 8; i++)
                    chk_eq($sformatf("a_mat[%0d]", i), 64'(mm_a_mat[i]), 64'(elem(m_base + 32'(i), m_cols)));
                chk_eq("b_vec", 64'(mm_b_vec), 64'(elem(m_base + 32'd8, m_cols)));
            end else begin
                chk_eq("idle_a_mat", 64'(mm_a_mat), 0);
                chk_eq("idle_b_vec", 64'(mm_b_vec), 0);
            end

            if (mm_clr) clr_seen++;
            prev_stall = mem_read && mem_waitrequest;
            prev_addr  = mem_address;
            if (outst && mem_readdatavalid) outst = 0;
            if (mem_read && !mem_waitrequest) outst = 1;

            if (m_cleared && m_rdv < m_reads && mem_readdatavalid) m_rdv++;
            if (exp_read && !mem_waitrequest) m_reads++;
            if (exp_wren) begin
                m_cols++;
                wren_seen++;
            end
            if (m_ldr_due) begin
                m_ldr_due = 0; m_busy = 0; m_idle = 1; m_cleared = 0;
            end else if (m_busy && m_cols == 8 && !exp_wren && mm_done) begin
                m_ldr_due = 1;
            end
            if (m_clr_due) begin
                m_clr_due = 0;
                m_cleared = 1;
            end
            if (m_idle && start) begin
                m_idle = 0; m_busy = 1; m_clr_due = 1; m_base = base_addr;
                m_reads = 0; m_rdv = 0; m_cols = 0;
            end
        end
    end

    task automatic at_cycle(input int n);
        @(negedge clk);
        while (cyc < t0 + n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [31:0] b);
        @(posedge clk); #1;
        start = 1; base_addr = b;
        t0 = cyc; wren_seen = 0; acc_cnt = 0; clr_seen = 0;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic pulse_raw_start(input logic [31:0] b);
        @(posedge clk); #1;
        start = 1; base_addr = b;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        mm_done = 1;
        @(posedge clk); #1;
        mm_done = 0;
    endtask

    task automatic wait_ldr(input int limit);
        bit found;
        found = 0;
        for (int k = 0; k < limit && !found; k++) begin
            @(negedge clk);
            if (ldr_done) found = 1;
        end
        chk_eq("ldr_done_seen", 64'(found), 1);
    endtask

    task automatic check_counts();
        chk_eq("wren_count", 64'(wren_seen), 8);
        chk_eq("read_count", 64'(acc_cnt), 9);
        chk_eq("clr_count", 64'(clr_seen), 1);
    endtask

    task automatic finish_job(input int delay);
        bit ok;
        ok = 0;
        for (int k = 0; k < 600 && !ok; k++) begin
            @(negedge clk);
            if (wren_seen == 8 && !mm_wren) ok = 1;
        end
        chk_eq("push_complete", 64'(ok), 1);
        repeat (delay) @(negedge clk);
        pulse_done();
        wait_ldr(20);
        check_counts();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst_n = 0; start = 0; base_addr = '0; mm_done = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);

        // basic load, zero-wait memory
        fill_basic(32'h0);
        cfg_wait = 0; cfg_lat = 1; cfg_rnd = 0;
        pulse_start(32'h0);
        at_cycle(1);
        chk_eq("basic_clr_c1", 64'(mm_clr), 1);
        chk_eq("basic_busy_c1", 64'(busy), 1);
        at_cycle(19);
        chk_eq("basic_wren_c19", 64'(mm_wren), 0);
        at_cycle(20);
        chk_eq("basic_wren_c20", 64'(mm_wren), 1);
        chk_eq("basic_a0_c20", 64'(mm_a_mat[0]), 1);
        chk_eq("basic_a7_c20", 64'(mm_a_mat[7]), 57);
        chk_eq("basic_b_c20", 64'(mm_b_vec), 1);
        at_cycle(27);
        chk_eq("basic_a7_c27", 64'(mm_a_mat[7]), 64);
        chk_eq("basic_a3_c27", 64'(mm_a_mat[3]), 32);
        chk_eq("basic_b_c27", 64'(mm_b_vec), 8);
        at_cycle(28);
        chk_eq("basic_wren_c28", 64'(mm_wren), 0);
        at_cycle(39);
        pulse_done();
        at_cycle(41);
        chk_eq("basic_ldr_c41", 64'(ldr_done), 1);
        chk_eq("basic_busy_c41", 64'(busy), 1);
        at_cycle(42);
        chk_eq("basic_busy_c42", 64'(busy), 0);
        check_counts();

        // waitrequest stalls: 3 stall cycles per read
        fill_rand(32'h40);
        cfg_wait = 3;
        pulse_start(32'h40);
        at_cycle(5);
        chk_eq("stall_read_c5", 64'(mem_read), 1);
        chk_eq("stall_addr_c5", 64'(mem_address), 64'h40);
        at_cycle(6);
        chk_eq("stall_read_c6", 64'(mem_read), 0);
        at_cycle(7);
        chk_eq("stall_addr_c7", 64'(mem_address), 64'h41);
        at_cycle(46);
        chk_eq("stall_wren_c46", 64'(mm_wren), 0);
        at_cycle(47);
        chk_eq("stall_wren_c47", 64'(mm_wren), 1);
        finish_job(2);

        // readdatavalid latency 4, spurious valid in IDLE, start while busy
        cfg_wait = 0; cfg_lat = 4;
        fill_rand(32'h80);
        @(negedge clk);
        spur_req = 1;
        repeat (3) @(negedge clk);
        pulse_start(32'h80);
        at_cycle(3);
        pulse_raw_start(32'h999);
        at_cycle(46);
        chk_eq("lat_wren_c46", 64'(mm_wren), 0);
        at_cycle(47);
        chk_eq("lat_wren_c47", 64'(mm_wren), 1);
        at_cycle(49);
        pulse_done();
        at_cycle(57);
        pulse_raw_start(32'h777);
        at_cycle(61);
        pulse_done();
        at_cycle(63);
        chk_eq("lat_ldr_c63", 64'(ldr_done), 1);
        at_cycle(64);
        chk_eq("lat_busy_c64", 64'(busy), 0);
        check_counts();

        // reset at the third push cycle, then a full job
        cfg_lat = 1;
        fill_rand(32'h200);
        pulse_start(32'h200);
        at_cycle(21);
        chk_eq("rst_wren_c21", 64'(mm_wren), 1);
        @(posedge clk); #2;
        rst_n = 0;
        @(negedge clk);
        chk_eq("rst_mid_wren", 64'(mm_wren), 0);
        chk_eq("rst_mid_busy", 64'(busy), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        pulse_start(32'h200);
        finish_job(1);

        // back-to-back: start the cycle after ldr_done
        fill_rand(32'h100);
        pulse_start(32'h100);
        at_cycle(1);
        chk_eq("b2b_clr_c1", 64'(mm_clr), 1);
        at_cycle(2);
        chk_eq("b2b_addr_c2", 64'(mem_address), 64'h100);
        finish_job(0);

        // randomized stalls, latencies, bases and completion delays
        cfg_rnd = 1;
        for (int r = 0; r < 6; r++) begin
            logic [31:0] b;
            b = 32'($urandom_range(0, 4000)) * 32'd16;
            fill_rand(b);
            pulse_start(b);
            finish_job(int'($urandom_range(0, 4)));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
